// File: rtl/riscv_data_mem_ctrl_if.sv
// riscv_data_mem_ctrl_if: load/store request/response bus between datapath (master) and data memory (slave)
interface riscv_data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/riscv_data_mem_ctrl.sv
// riscv_data_mem_ctrl: fixed-latency byte/half/word data RAM behind a valid/ready load/store bus; DMEM_ERR_EN enables fault reporting
module riscv_data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                   clk,
  input logic                   rst,
  riscv_data_mem_ctrl_if.slave  dmem
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q, ready_q, valid_q, err_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          in_idle, do_acc, acc_we, acc_err, is_byte, is_half, sext, wr_en, unused_addr;
  logic [2:0]    acc_f3;
  logic [1:0]    lane;
  logic [3:0]    wmask;
  logic [IW-1:0] idx;
  logic [31:0]   acc_addr, acc_wdata, word, ld_sh, ld, wdata_sh;
  // With LATENCY==1 the access happens on the accept edge, so it uses the live request
  assign in_idle   = state_q == IDLE;
  assign acc_we    = in_idle ? dmem.req_we     : we_q;
  assign acc_addr  = in_idle ? dmem.req_addr   : addr_q;
  assign acc_f3    = in_idle ? dmem.req_funct3 : f3_q;
  assign acc_wdata = in_idle ? dmem.req_wdata  : wdata_q;
  assign do_acc    = (LATENCY == 1 && in_idle && dmem.req_valid) || (state_q == WAIT && cnt_q == '0);
  assign is_byte   = acc_we ? acc_f3 == 3'b000 : acc_f3[1:0] == 2'b00;
  assign is_half   = acc_we ? acc_f3 == 3'b001 : acc_f3[1:0] == 2'b01;
  assign sext      = ~acc_f3[2];
  assign lane      = acc_addr[1:0];
  assign idx       = acc_addr[IW+1:2];
  assign word      = mem[idx];
  assign ld_sh     = is_byte ? word >> {lane, 3'b000} : is_half ? word >> {acc_addr[1], 4'b0000} : word;
  assign ld        = is_byte ? {{24{sext & ld_sh[7]}}, ld_sh[7:0]} :
                     is_half ? {{16{sext & ld_sh[15]}}, ld_sh[15:0]} : ld_sh;
  assign wmask     = is_byte ? 4'b0001 << lane : is_half ? (acc_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_sh  = is_byte ? {4{acc_wdata[7:0]}} : is_half ? {2{acc_wdata[15:0]}} : acc_wdata;
`ifdef DMEM_ERR_EN
  assign acc_err   = !(is_byte || is_half || acc_f3 == 3'b010) || (is_half && acc_addr[0]) ||
                     (acc_f3 == 3'b010 && lane != 2'b00);
`else
  assign acc_err   = 1'b0;
`endif
  assign wr_en       = do_acc && acc_we && !acc_err && !rst;
  assign unused_addr = ^acc_addr[31:IW+2];
  assign dmem.req_ready = ready_q;
  assign dmem.rsp_valid = valid_q;
  assign dmem.rsp_rdata = rdata_q;
  assign dmem.rsp_err   = err_q;
  always_ff @(posedge clk)
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (do_acc) begin
        rdata_q <= (acc_we || acc_err) ? '0 : ld;
        err_q   <= acc_err;
      end
      case (state_q)
        IDLE: if (dmem.req_valid) begin
          we_q    <= dmem.req_we;
          addr_q  <= dmem.req_addr;
          f3_q    <= dmem.req_funct3;
          wdata_q <= dmem.req_wdata;
          cnt_q   <= CW'(LATENCY - 1);
          state_q <= LATENCY == 1 ? RESP : WAIT;
          ready_q <= 1'b0;
          valid_q <= LATENCY == 1;
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end
        end
        RESP: if (dmem.rsp_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_data_mem_ctrl.sv
// tb_riscv_data_mem_ctrl: random and directed load/store traffic checked against a byte-array memory model
module tb_riscv_data_mem_ctrl;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int NB    = DEPTH * 4;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  riscv_data_mem_ctrl_if bus ();
  riscv_data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .dmem(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mb [NB];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int acc_size(input bit we, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return we ? 4 : 1;
      3'd5: return we ? 4 : 2;
      default: return 4;
    endcase
  endfunction
  function automatic bit listed(input bit we, input logic [2:0] f3);
    return f3 <= 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5));
  endfunction
  task automatic model(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int sz, base;
    longint v;
    sz   = acc_size(we, f3);
    err  = ERR_EN && (!listed(we, f3) || (addr % sz) != 0);
    rd   = '0;
    v    = 0;
    base = int'(addr & (NB - 1)) & ~(sz - 1);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mb[base + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v = v | (longint'(mb[base + i]) << (8 * i));
        if (f3 < 3'd2 && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        rd = v[31:0];
      end
    end
  endtask
  task automatic check_reset_state();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err",   bus.rsp_err,   0);
  endtask
  task automatic xact(input bit we, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                      input int hold, input bit poke, output logic [31:0] got, output bit got_err);
    logic [31:0] erd;
    bit eerr;
    int k;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    model(we, addr, f3, wd, erd, eerr);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    check("latency", k, LAT);
    check("rsp_rdata", bus.rsp_rdata, erd);
    check("rsp_err", bus.rsp_err, eerr);
    got     = bus.rsp_rdata;
    got_err = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h40;
        bus.req_funct3 = 3'b010;
        bus.req_wdata  = 32'hBAD0BAD0;
      end
      @(posedge clk);
      #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, erd);
      check("hold_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check("done_valid", bus.rsp_valid, 0);
    check("done_ready", bus.req_ready, 1);
  endtask
  initial begin
    logic [31:0] got, addr;
    logic [2:0] f3;
    bit gerr, we;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();
    for (int w = 0; w < DEPTH; w++) xact(1'b1, 32'(w * 4), 3'b010, $urandom, 0, 1'b0, got, gerr);
    xact(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 1'b0, got, gerr);
    xact(1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b0, got, gerr);
    check("lw_10", got, 32'hDEADBEEF);
    xact(1'b0, 32'h13, 3'b000, 32'h0, 0, 1'b0, got, gerr);
    check("lb_13", got, 32'hFFFFFFDE);
    xact(1'b0, 32'h13, 3'b100, 32'h0, 0, 1'b0, got, gerr);
    check("lbu_13", got, 32'h000000DE);
    xact(1'b0, 32'h10, 3'b001, 32'h0, 0, 1'b0, got, gerr);
    check("lh_10", got, 32'hFFFFBEEF);
    xact(1'b0, 32'h12, 3'b101, 32'h0, 0, 1'b0, got, gerr);
    check("lhu_12", got, 32'h0000DEAD);
    xact(1'b1, 32'h11, 3'b000, 32'h55, 0, 1'b0, got, gerr);
    check("sb_rdata_zero", got, 32'h0);
    xact(1'b0, 32'h10, 3'b010, 32'h0, 5, 1'b1, got, gerr);
    check("lw_10_after_sb", got, 32'hDEAD55EF);
    xact(1'b0, 32'h40, 3'b010, 32'h0, 0, 1'b0, got, gerr);
    xact(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 0, 1'b0, got, gerr);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_funct3 = 3'b010;
    bus.req_wdata  = 32'h12345678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();
    xact(1'b0, 32'h20, 3'b010, 32'h0, 0, 1'b0, got, gerr);
    check("lw_20_store_dropped", got, 32'hCAFEF00D);
    xact(1'b0, 32'h22, 3'b010, 32'h0, 0, 1'b0, got, gerr);
    check("lw_22_rdata", got, ERR_EN ? 32'h0 : 32'hCAFEF00D);
    check("lw_22_err", gerr, ERR_EN);
    xact(1'b0, 32'h1010, 3'b010, 32'h0, 0, 1'b0, got, gerr);
    check("lw_wrap", got, 32'hDEAD55EF);
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
      f3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      xact(we, addr, f3, $urandom, $urandom_range(0, 2), 1'b0, got, gerr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
